// File: rtl/mac_scheduler.sv
// mac_scheduler: round-robin arbiter that shares one sequential signed
// multiplier between two requesters and folds each product into that
// requester's private wrapping accumulator.
module mac_scheduler #(
  parameter int DW      = 8,
  parameter int ACC_W   = 20,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic signed [DW-1:0]    req0_x,
  input  logic signed [DW-1:0]    req0_y,
  input  logic                    req0_clr,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic signed [DW-1:0]    req1_x,
  input  logic signed [DW-1:0]    req1_y,
  input  logic                    req1_clr,
  output logic                    mul_start,
  output logic signed [DW-1:0]    mul_x,
  output logic signed [DW-1:0]    mul_y,
  input  logic                    mul_valid,
  input  logic signed [2*DW-1:0]  mul_p,
  output logic signed [ACC_W-1:0] acc0,
  output logic signed [ACC_W-1:0] acc1,
  output logic [1:0]              done,
  output logic                    busy,
  output logic                    err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // An accumulator narrower than a full product would silently drop bits.
  if (ACC_W < 2*DW) begin : g_acc_w_check
    $error("mac_scheduler: ACC_W must be at least 2*DW");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM
  } state_e;

  state_e                   state_q;
  logic                     last_q;
  logic                     id_q;
  logic                     clr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [DW-1:0]     x_q;
  logic signed [DW-1:0]     y_q;
  logic                     start_q;
  logic signed [ACC_W-1:0]  acc0_q;
  logic signed [ACC_W-1:0]  acc1_q;
  logic [1:0]               done_q;
  logic                     err_q;
  logic signed [2*DW-1:0]   prod_q;
  logic [1:0]               grant_d;

  // Sign-extend the product and add it to the (optionally cleared) base;
  // the sum wraps modulo 2^ACC_W.
  function automatic logic signed [ACC_W-1:0] acc_update(
    input logic signed [ACC_W-1:0] base,
    input logic signed [2*DW-1:0]  p,
    input logic                    clr
  );
    logic signed [ACC_W-1:0] ext;
    ext = ACC_W'(p);
    return (clr ? '0 : base) + ext;
  endfunction

  // Grant selection: a lone requester always wins; under contention the
  // requester that was not served last wins.
  always_comb begin
    grant_d = 2'b00;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_d = last_q ? 2'b01 : 2'b10;
      end else begin
        grant_d = {req1_valid, req0_valid};
      end
    end
  end

  assign req0_ready = grant_d[0];
  assign req1_ready = grant_d[1];

  // Product register: only meaningful while the FSM is in ACCUM, so no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT && mul_valid) begin
      prod_q <= mul_p;
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      clr_q   <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      start_q <= 1'b0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 2'b00;
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_d != 2'b00) begin
            id_q    <= grant_d[1];
            clr_q   <= grant_d[1] ? req1_clr : req0_clr;
            x_q     <= grant_d[1] ? req1_x : req0_x;
            y_q     <= grant_d[1] ? req1_y : req0_y;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_valid) begin
            state_q <= S_ACCUM;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Multiplier never answered: abandon the operation.
            err_q   <= 1'b1;
            last_q  <= id_q;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (id_q) begin
            acc1_q <= acc_update(acc1_q, prod_q, clr_q);
          end else begin
            acc0_q <= acc_update(acc0_q, prod_q, clr_q);
          end
          done_q  <= id_q ? 2'b10 : 2'b01;
          last_q  <= id_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_start = start_q;
  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign acc0      = acc0_q;
  assign acc1      = acc1_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_mac_scheduler.sv
// Testbench for mac_scheduler: transaction-level model of grant order,
// turnaround timing and accumulator contents, checked every cycle, plus
// hand-computed literal expectations.
module tb_mac_scheduler;

  localparam int DW      = 8;
  localparam int ACC_W   = 20;
  localparam int TIMEOUT = 15;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    req0_valid, req0_clr, req1_valid, req1_clr;
  logic signed [DW-1:0]    req0_x, req0_y, req1_x, req1_y;
  logic                    req0_ready, req1_ready;
  logic                    mul_start, mul_valid;
  logic signed [DW-1:0]    mul_x, mul_y;
  logic signed [2*DW-1:0]  mul_p;
  logic signed [ACC_W-1:0] acc0, acc1;
  logic [1:0]              done;
  logic                    busy, err;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  logic [ACC_W-1:0]     m_acc [2];
  logic                 m_last, m_err, m_busy, m_id, m_clr;
  int                   m_age, m_end, m_lat;
  logic signed [DW-1:0] m_x, m_y;
  logic [1:0]           xfer;

  // Multiplier model: product returned mul_lat cycles after mul_start (0 = never).
  int                   mul_lat = 9;
  int                   pend = 0;
  logic signed [15:0]   px;
  logic                 spur = 1'b0;

  int n_start = 0, n_done0 = 0, n_done1 = 0;

  mac_scheduler #(.DW(DW), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_clr(req0_clr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_clr(req1_clr),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y), .mul_valid(mul_valid), .mul_p(mul_p),
    .acc0(acc0), .acc1(acc1), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] u(input logic [ACC_W-1:0] v);
    return {{(32-ACC_W){1'b0}}, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc[0] = '0;
    m_acc[1] = '0;
    m_last   = 1'b1;
    m_err    = 1'b0;
    m_busy   = 1'b0;
    m_age    = 0;
  endtask

  // Called at the falling edge: advance the model one cycle and compare.
  task automatic compare_cycle();
    logic [1:0] exp_done;
    logic [1:0] g;
    logic       exp_start;
    int         p;
    exp_done = 2'b00;
    xfer     = 2'b00;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      m_age++;
      if (m_age == m_end + 1) begin
        m_busy = 1'b0;
        if (m_lat != 0) begin
          p = int'(m_x) * int'(m_y);
          m_acc[m_id] = (m_clr ? '0 : m_acc[m_id]) + ACC_W'(p);
          exp_done[m_id] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_last = m_id;
      end
    end
    exp_start = m_busy && (m_age == 1);
    g = 2'b00;
    if (!m_busy) begin
      if (req0_valid && req1_valid) g = m_last ? 2'b01 : 2'b10;
      else                          g = {req1_valid, req0_valid};
    end
    chk("acc0", u(acc0), u(m_acc[0]));
    chk("acc1", u(acc1), u(m_acc[1]));
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("err", 32'(err), 32'(m_err));
    chk("mul_start", 32'(mul_start), 32'(exp_start));
    chk("req0_ready", 32'(req0_ready), 32'(g[0]));
    chk("req1_ready", 32'(req1_ready), 32'(g[1]));
    if (exp_start) begin
      chk("mul_x", 32'(unsigned'(mul_x)), 32'(unsigned'(m_x)));
      chk("mul_y", 32'(unsigned'(mul_y)), 32'(unsigned'(m_y)));
    end
    if (mul_start) begin
      n_start++;
      pend = mul_lat;
      px   = $signed(mul_x) * $signed(mul_y);
    end
    if (done[0]) n_done0++;
    if (done[1]) n_done1++;
    if (rst_n && g != 2'b00) begin
      xfer   = g;
      m_busy = 1'b1;
      m_age  = 0;
      m_id   = g[1];
      m_clr  = g[1] ? req1_clr : req0_clr;
      m_x    = g[1] ? req1_x : req0_x;
      m_y    = g[1] ? req1_y : req0_y;
      m_lat  = mul_lat;
      m_end  = (mul_lat != 0) ? mul_lat + 2 : TIMEOUT + 1;
    end
  endtask

  // Called just after the rising edge: drive the multiplier response.
  task automatic mul_drive();
    mul_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mul_valid = 1'b1;
        mul_p     = px;
      end
    end
    if (spur) begin
      mul_valid = 1'b1;
      mul_p     = 16'h1234;
      spur      = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    mul_drive();
    if (xfer[0]) req0_valid = 1'b0;
    if (xfer[1]) req1_valid = 1'b0;
  endtask

  task automatic issue(input int k, input int x, input int y, input logic clr);
    if (k == 0) begin
      req0_x = DW'(x); req0_y = DW'(y); req0_clr = clr; req0_valid = 1'b1;
    end else begin
      req1_x = DW'(x); req1_y = DW'(y); req1_clr = clr; req1_valid = 1'b1;
    end
  endtask

  task automatic run(input string name);
    int n;
    n = 0;
    while ((req0_valid || req1_valid || m_busy) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_bound: still busy after %0d cycles, want idle", name, n);
    end
  endtask

  initial begin
    int s0, d0, d1;
    req0_valid = 0; req0_clr = 0; req0_x = 0; req0_y = 0;
    req1_valid = 0; req1_clr = 0; req1_x = 0; req1_y = 0;
    mul_valid = 0; mul_p = 0;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    chk("init_acc0", u(acc0), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // req0 3 * -4 with clear.
    s0 = n_start; d0 = n_done0; d1 = n_done1;
    issue(0, 3, -4, 1'b1);
    run("t2");
    chk("t2_acc0", u(acc0), 32'h000FFFF4);
    chk("t2_acc1", u(acc1), 32'h0);
    chk("t2_starts", 32'(n_start - s0), 32'd1);
    chk("t2_done0", 32'(n_done0 - d0), 32'd1);
    chk("t2_done1", 32'(n_done1 - d1), 32'd0);

    // Reset while the multiplier is working; its late valid lands in IDLE.
    issue(0, 3, 3, 1'b0);
    step(); step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_acc0", u(acc0), 32'h0);
    chk("rst_acc1", u(acc1), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start", 32'(mul_start), 32'h0);
    chk("rst_mul_x", 32'(unsigned'(mul_x)), 32'h0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rst_late_acc0", u(acc0), 32'h0);

    // Contention: req0 wins first after reset, then req1.
    issue(0, 2, 5, 1'b1);
    issue(1, -7, -7, 1'b1);
    step();
    chk("t3_first_grant", 32'(xfer), 32'h1);
    run("t3");
    chk("t3_acc0", u(acc0), 32'd10);
    chk("t3_acc1", u(acc1), 32'd49);
    issue(0, 1, 1, 1'b0);
    issue(1, 1, 1, 1'b0);
    step();
    chk("t3_rr_grant", 32'(xfer), 32'h1);
    run("t3b");
    chk("t3b_acc0", u(acc0), 32'd11);
    chk("t3b_acc1", u(acc1), 32'd50);

    // 66 back-to-back 127*127 products wrap the accumulator.
    for (int i = 0; i < 66; i++) begin
      issue(0, 127, 127, (i == 0));
      run("t4");
    end
    chk("t4_wrap", u(acc0), 32'd15938);
    issue(0, -128, -128, 1'b1);
    run("t4b");
    chk("t4_minmin", u(acc0), 32'd16384);

    // Multiplier that never answers.
    mul_lat = 0;
    d0 = n_done0;
    issue(0, 5, 5, 1'b0);
    run("t5");
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_acc0", u(acc0), 32'd16384);
    chk("t5_nodone", 32'(n_done0 - d0), 32'd0);
    mul_lat = 9;
    issue(1, -3, 4, 1'b1);
    run("t5b");
    chk("t5b_acc1", u(acc1), 32'h000FFFF4);
    chk("t5b_err", 32'(err), 32'h1);

    // Request dropped before grant, and spurious mul_valid in IDLE.
    mul_lat = 1;
    s0 = n_start; d1 = n_done1;
    issue(0, 2, 2, 1'b0);
    step(); step();
    issue(1, 9, 9, 1'b1);
    step();
    req1_valid = 1'b0;
    run("t6");
    spur = 1'b1;
    step(); step(); step();
    chk("t6_acc0", u(acc0), 32'd16388);
    chk("t6_acc1", u(acc1), 32'h000FFFF4);
    chk("t6_starts", 32'(n_start - s0), 32'd1);
    chk("t6_done1", 32'(n_done1 - d1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
